ysyx_25020037_wbu: RTL
======================

Name: ysyx_25020037_wbu

Overview:
Write-back unit sitting between the LSU and the register file / CSR block. It accepts completed instructions from the LSU over a valid/ready handshake and formats load data. It selects the GPR write-back value and buffers up to 2 results. It then presents each result to the register file as wbu_valid plus the {gpr_wen, gpr_wdata} bus, completing the writer side of the GPR handshake. It also produces CSR write data and a retire pulse/counter for difftest.

Parameters:
DEPTH, 2, result buffer entries (power of two, ≥2)
XLEN, 32, datapath width

Ports:
clk  input  1  clock
rst  input  1  async active-high reset
lsu_valid  input  1  upstream result valid
wbu_ready  output  1  upstream may transfer (buffer not full)
in_pc  input  32  instruction PC
in_rd  input  5  destination register
in_rf_we  input  1  instruction writes GPR
in_wb_sel  input  2  0=ALU, 1=load, 2=PC+4, 3=CSR read
in_alu_res  input  32  ALU result
in_load_raw  input  32  raw 32-bit word from memory
in_addr_lo  input  2  load byte offset
in_load_type  input  3  0=lb 1=lh 2=lw 4=lbu 5=lhu
in_csr_rdata  input  32  old CSR value
in_csr_wdata  input  32  new CSR value
gpr_ready  input  1  register file accepts write
wbu_valid  output  1  write-back request to register file
gpr_we  output  1  GPR write enable
wu_to_gu_bus  output  33  {gpr_wen, gpr_wdata}
csr_wcsr_data  output  32  CSR write data of head entry
retire_valid  output  1  one-cycle pulse per completed write-back
retire_pc  output  32  PC of retired instruction
retire_cnt  output  32  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: buffer empty (count=0, rd/wr pointers 0), wbu_ready=1, wbu_valid=0, gpr_we=0, wu_to_gu_bus=0, csr_wcsr_data=0, retire_valid=0, retire_pc=0, retire_cnt=0.
- Upstream transfer: occurs on any rising edge where lsu_valid & wbu_ready. wbu_ready = (count != DEPTH), combinational from registered count only.
- Entry formatting is done at enqueue and stored in the buffer. The entry holds pc, rd, we, wdata and csr_wdata.
  - Load: byte = raw[8*addr_lo +: 8]; half = raw[16*addr_lo[1] +: 16]. lb/lh sign-extend, lbu/lhu zero-extend, lw uses the raw word. addr_lo is ignored for lw.
  - Undefined load_type yields 0.
  - PC+4 wraps modulo 2^32.
  - we = in_rf_we & (in_rd != 0). x0 is never written.
- Downstream outputs:
  - wbu_valid = (count != 0).
  - gpr_we, wu_to_gu_bus and csr_wcsr_data reflect the head entry and are 0 when empty.
  - Outputs must stay stable while wbu_valid=1 and no transfer has occurred.
- Downstream transfer: occurs on a rising edge where wbu_valid & gpr_ready. The head is dequeued at that edge. The next entry, if any, is presented the following cycle with wbu_valid held high.
  - Back-to-back transfers are allowed whenever gpr_ready stays high.
- Simultaneous enqueue and dequeue: count unchanged.
  - When full, wbu_ready=0, so no enqueue occurs even though a dequeue happens in the same cycle. There is no same-cycle bypass.
- Empty: there is no bypass from lsu_valid to wbu_valid. Minimum latency is 1 cycle from the accept edge to wbu_valid=1.
- Pointers wrap modulo DEPTH.
- Retire: on each downstream transfer edge, retire_valid=1 for the following cycle only, with retire_pc = the dequeued pc. retire_cnt increments by 1 and wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: all entries are discarded immediately and outputs return to reset values asynchronously. No partial write is issued after reset deasserts.

Test Plan:
- Reset mid-stream: with 2 entries buffered, assert rst asynchronously mid-cycle -> wbu_valid=0, wbu_ready=1, retire_cnt=0 immediately; the first post-reset accept behaves like the ALU case.
- ALU path: in_wb_sel=0, rd=5, alu_res=0x12345678, gpr_ready=1 -> one cycle later wbu_valid=1, wu_to_gu_bus=0x1_12345678; next edge retire_valid=1, retire_pc=in_pc, retire_cnt=1.
- Load formatting: raw=0x80FF7F01 -> lb off3 gives 0xFFFFFF80; lbu off1 gives 0x0000007F; lh off2 gives 0xFFFF80FF; lhu off0 gives 0x00007F01; lw gives 0x80FF7F01.
- x0 and PC+4: rd=0, rf_we=1 -> gpr_we=0, bus MSB=0, still retires. wb_sel=2, pc=0xFFFFFFFC -> wdata=0x00000000.
- Backpressure/full: hold gpr_ready=0 and push 3 results -> wbu_ready=0 after 2 accepted, third held. Raise gpr_ready -> entries drain in order on consecutive cycles and the third is accepted in the cycle after the first dequeue.
- Counter wrap: force retire_cnt to 0xFFFFFFFF via a long run or backdoor, retire one instruction -> retire_cnt=0.

Source files
------------

// File: rtl/ysyx_25020037_wbu_if.sv
// Handshake bundle between the LSU, the write-back unit and the register file.
// It also carries the CSR write data and the difftest retire signals.
interface ysyx_25020037_wbu_if #(
   parameter int XLEN = 32
);
   logic            lsu_valid;
   logic            wbu_ready;
   logic [XLEN-1:0] in_pc;
   logic [4:0]      in_rd;
   logic            in_rf_we;
   logic [1:0]      in_wb_sel;
   logic [XLEN-1:0] in_alu_res;
   logic [31:0]     in_load_raw;
   logic [1:0]      in_addr_lo;
   logic [2:0]      in_load_type;
   logic [XLEN-1:0] in_csr_rdata;
   logic [XLEN-1:0] in_csr_wdata;
   logic            gpr_ready;
   logic            wbu_valid;
   logic            gpr_we;
   logic [XLEN:0]   wu_to_gu_bus;
   logic [XLEN-1:0] csr_wcsr_data;
   logic            retire_valid;
   logic [XLEN-1:0] retire_pc;
   logic [31:0]     retire_cnt;

   modport slave (
      input  lsu_valid, in_pc, in_rd, in_rf_we, in_wb_sel,
      input  in_alu_res, in_load_raw, in_addr_lo, in_load_type,
      input  in_csr_rdata, in_csr_wdata, gpr_ready,
      output wbu_ready, wbu_valid, gpr_we, wu_to_gu_bus,
      output csr_wcsr_data, retire_valid, retire_pc, retire_cnt
   );

   modport master (
      output lsu_valid, in_pc, in_rd, in_rf_we, in_wb_sel,
      output in_alu_res, in_load_raw, in_addr_lo, in_load_type,
      output in_csr_rdata, in_csr_wdata, gpr_ready,
      input  wbu_ready, wbu_valid, gpr_we, wu_to_gu_bus,
      input  csr_wcsr_data, retire_valid, retire_pc, retire_cnt
   );
endinterface

// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: formats LSU results and buffers them in a small FIFO.
// It presents each buffered result to the GPR file and counts retirements.
module ysyx_25020037_wbu #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input logic               clk,
   input logic               rst,
   ysyx_25020037_wbu_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW:0]     r_count;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [XLEN-1:0] r_pc   [DEPTH];
   logic            r_we   [DEPTH];
   logic [XLEN-1:0] r_wdata[DEPTH];
   logic [XLEN-1:0] r_csr  [DEPTH];
   logic            r_retire_valid;
   logic [XLEN-1:0] r_retire_pc;
   logic [31:0]     r_retire_cnt;

   logic            w_nonempty;
   logic            w_push;
   logic            w_pop;
   logic            w_we;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load;
   logic [XLEN-1:0] w_wdata;

   assign w_nonempty    = (r_count != '0);
   assign bus.wbu_ready = (r_count != FULL);
   assign bus.wbu_valid = w_nonempty;
   assign w_push        = bus.lsu_valid & bus.wbu_ready;
   assign w_pop         = w_nonempty & bus.gpr_ready;
   assign w_we          = bus.in_rf_we & (bus.in_rd != 5'd0);

   always_comb begin
      w_byte = bus.in_load_raw[{bus.in_addr_lo, 3'b000} +: 8];
      w_half = bus.in_addr_lo[1] ? bus.in_load_raw[31:16]
                                 : bus.in_load_raw[15:0];
      w_load = '0;
      case (bus.in_load_type)
         3'd0:    w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'd1:    w_load = {{(XLEN-16){w_half[15]}}, w_half};
         3'd2:    w_load = bus.in_load_raw;
         3'd4:    w_load = {{(XLEN-8){1'b0}}, w_byte};
         3'd5:    w_load = {{(XLEN-16){1'b0}}, w_half};
         default: w_load = '0;
      endcase
   end

   always_comb begin
      w_wdata = bus.in_alu_res;
      unique case (bus.in_wb_sel)
         2'd0: w_wdata = bus.in_alu_res;
         2'd1: w_wdata = w_load;
         2'd2: w_wdata = bus.in_pc + XLEN'(4);
         2'd3: w_wdata = bus.in_csr_rdata;
      endcase
   end

   // Payload needs no reset: it is only visible while r_count is nonzero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr_ptr]    <= bus.in_pc;
         r_we[r_wr_ptr]    <= w_we;
         r_wdata[r_wr_ptr] <= w_wdata;
         r_csr[r_wr_ptr]   <= bus.in_csr_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retire_valid <= 1'b0;
         r_retire_pc    <= '0;
         r_retire_cnt   <= '0;
      end else begin
         r_retire_valid <= w_pop;
         if (w_pop) begin
            r_retire_pc  <= r_pc[r_rd_ptr];
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
      end
   end

   assign bus.gpr_we        = w_nonempty & r_we[r_rd_ptr];
   assign bus.wu_to_gu_bus  = w_nonempty ? {r_we[r_rd_ptr], r_wdata[r_rd_ptr]}
                                         : '0;
   assign bus.csr_wcsr_data = w_nonempty ? r_csr[r_rd_ptr] : '0;
   assign bus.retire_valid  = r_retire_valid;
   assign bus.retire_pc     = r_retire_pc;
   assign bus.retire_cnt    = r_retire_cnt;
endmodule
